// File: rtl/riscv_pkg.sv
// Shared RV32I types and constants for the single-cycle core.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_read_port.sv
// Combinational register-file read mux with x0 zero-forcing and optional write-through
// forwarding (enabled by REGFILE_BYPASS_EN).
module regfile_read_port #(
  parameter int unsigned ADDR_W = riscv_pkg::REG_ADDR_W,
  parameter int unsigned XLEN   = riscv_pkg::XLEN
) (
  input  logic [ADDR_W-1:0] ra_i,
  input  logic [XLEN-1:0]   regs_i [1:(2**ADDR_W)-1],
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [XLEN-1:0]   wd_i,
  output logic [XLEN-1:0]   rd_o
);
  import riscv_pkg::*;

  logic ra_is_zero;
  assign ra_is_zero = (ra_i == ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
  logic fwd_hit;
  assign fwd_hit = we_i && (wa_i != ADDR_W'(REG_ZERO)) && (wa_i == ra_i);

  always_comb begin
    rd_o = '0;
    if (fwd_hit) begin
      rd_o = wd_i;
    end else if (!ra_is_zero) begin
      rd_o = regs_i[ra_i];
    end
  end
`else
  // Write-port inputs only matter when forwarding is built in.
  logic unused_fwd;
  assign unused_fwd = ^{we_i, wa_i, wd_i};

  always_comb begin
    rd_o = '0;
    if (!ra_is_zero) begin
      rd_o = regs_i[ra_i];
    end
  end
`endif

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: two async read ports, one sync write port, x0 hardwired to 0.
// Optional same-cycle write-through forwarding via REGFILE_BYPASS_EN.
module register_file #(
  parameter int unsigned ADDR_W = riscv_pkg::REG_ADDR_W,
  parameter int unsigned XLEN   = riscv_pkg::XLEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [XLEN-1:0]   wd3,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  // Entry 0 has no storage; x0 is synthesised as a constant in the read ports.
  logic [XLEN-1:0] mem_q [1:NumRegs-1];
  logic [XLEN-1:0] mem_d [1:NumRegs-1];

  always_comb begin
    mem_d = mem_q;
    if (we3 && (wa3 != '0)) begin
      mem_d[wa3] = wd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NumRegs; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  regfile_read_port #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN)
  ) u_read_port1 (
    .ra_i   (ra1),
    .regs_i (mem_q),
    .we_i   (we3),
    .wa_i   (wa3),
    .wd_i   (wd3),
    .rd_o   (rd1)
  );

  regfile_read_port #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN)
  ) u_read_port2 (
    .ra_i   (ra2),
    .regs_i (mem_q),
    .we_i   (we3),
    .wa_i   (wa3),
    .wd_i   (wd3),
    .rd_o   (rd2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed plus randomized bench for register_file against an array reference model.
module tb_register_file;

  logic        clk;
  logic        clk_en;
  logic        reset_n;
  logic        we3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int n_cmp;
  int n_err;

  // Architectural view: 32 registers, x0 always reads 0.
  logic [31:0] model [32];

  register_file #(
    .ADDR_W (5),
    .XLEN   (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .we3     (we3),
    .ra1     (ra1),
    .ra2     (ra2),
    .wa3     (wa3),
    .wd3     (wd3),
    .rd1     (rd1),
    .rd2     (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = clk_en ? ~clk : clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] ra);
    logic [31:0] v;
    v = (ra == 5'd0) ? 32'd0 : model[ra];
`ifdef REGFILE_BYPASS_EN
    if (we3 && wa3 != 5'd0 && wa3 == ra) v = wd3;
`endif
    return v;
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    we3 = 1'b1;
    wa3 = a;
    wd3 = d;
    @(posedge clk);
    #1;
    if (a != 5'd0) model[a] = d;
    we3 = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    clk_en  = 1'b0;
    reset_n = 1'b1;
    we3     = 1'b0;
    ra1     = '0;
    ra2     = '0;
    wa3     = '0;
    wd3     = '0;
    clear_model();

    // Reset with the clock stopped: clearing must not need an edge.
    #3 reset_n = 1'b0;
    #3;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      check("reset_rd1", rd1, 32'd0);
      check("reset_rd2", rd2, 32'd0);
    end
    reset_n = 1'b1;
    #2 clk_en = 1'b1;

    // Fill mem[i] = 2*i, then sweep both ports.
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'(2 * i));
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'((i << 2) % 32);
      #1;
      check("fill_rd1", rd1, 32'(2 * i));
      check("fill_rd2", rd2, 32'(2 * ((i << 2) % 32)));
    end
    ra1 = 5'd5;
    ra2 = 5'd20;
    #1;
    check("example_rd1", rd1, 32'h0000_000A);
    check("example_rd2", rd2, 32'h0000_0028);

    // x0 ignores writes.
    do_write(5'd0, 32'hDEAD_BEEF);
    ra1 = 5'd0;
    ra2 = 5'd0;
    #1;
    check("x0_rd1", rd1, 32'd0);
    check("x0_rd2", rd2, 32'd0);

    // Write-enable gating.
    do_write(5'd7, 32'h11);
    wa3 = 5'd7;
    wd3 = 32'hFF;
    we3 = 1'b0;
    @(posedge clk);
    #1;
    ra1 = 5'd7;
    #1;
    check("we_gate_rd1", rd1, 32'h11);

    // Same-cycle read/write to the same address.
    do_write(5'd9, 32'h12);
    ra1 = 5'd9;
    we3 = 1'b1;
    wa3 = 5'd9;
    wd3 = 32'h34;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rw_same_pre", rd1, 32'h34);
`else
    check("rw_same_pre", rd1, 32'h12);
`endif
    @(posedge clk);
    #1;
    model[9] = 32'h34;
    we3 = 1'b0;
    check("rw_same_post", rd1, 32'h34);

    // Randomized traffic against the model, checked just before each edge.
    for (int n = 0; n < 300; n++) begin
      we3 = 1'($urandom_range(0, 3) != 0);
      wa3 = 5'($urandom_range(0, 31));
      wd3 = $urandom();
      ra1 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      #2;
      check("rand_rd1", rd1, expect_rd(ra1));
      check("rand_rd2", rd2, expect_rd(ra2));
      @(posedge clk);
      if (we3 && wa3 != 5'd0) model[wa3] = wd3;
      #1;
    end
    we3 = 1'b0;

    // Async reset between edges, then reset colliding with a write.
    do_write(5'd3, 32'hAA);
    ra1 = 5'd3;
    #1;
    check("pre_reset_rd1", rd1, 32'hAA);
    reset_n = 1'b0;
    #1;
    check("async_reset_rd1", rd1, 32'd0);
    clear_model();
    we3 = 1'b1;
    wa3 = 5'd3;
    wd3 = 32'h55;
    @(posedge clk);
    #1;
    check("reset_wins_rd1", rd1, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra2 = 5'(i);
      #0;
      check("reset_all_rd2", rd2, model[i]);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    model[3] = 32'h55;
    we3 = 1'b0;
    check("first_write_rd1", rd1, 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
